// File: rtl/norm_unit.sv
// norm_unit: multi-cycle left-normalizer for the 16-bit datapath.
// Shifts a value left one bit per cycle until bit 15 is set and reports
// the number of shifts applied (leading-zero count).
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst      in   1   asynchronous active-high reset
//   i_start  in   1   request pulse, sampled only in IDLE
//   i_in     in  16   value to normalize, sampled with an accepted start
//   o_out    out 16   normalized value (bit 15 set unless o_zero)
//   o_cnt    out  4   left shifts applied
//   o_zero   out  1   accepted input was zero
//   o_busy   out  1   high in SHIFT and DONE
//   o_done   out  1   one-cycle completion pulse
module norm_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_in,
    output logic [15:0] o_out,
    output logic [3:0]  o_cnt,
    output logic        o_zero,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_data;
    logic [15:0] w_data_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_zero;
    logic        w_zero_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= 16'h0000;
            r_cnt   <= 4'h0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_zero_nxt  = r_zero;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_data_nxt = i_in;
                    w_cnt_nxt  = 4'h0;
                    w_zero_nxt = (i_in == 16'h0000);
                    // A zero input can never normalize; skip SHIFT.
                    w_state_nxt = (i_in == 16'h0000) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_data[15]) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_data_nxt = {r_data[14:0], 1'b0};
                    // At most 15 shifts for a nonzero value: no wrap.
                    w_cnt_nxt  = r_cnt + 4'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_out  = r_data;
    assign o_cnt  = r_cnt;
    assign o_zero = r_zero;
    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);

endmodule
